// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, default widths and size helpers shared by
// the conv sequencer. Optional ReLU on results: CONV_SEQ_CTRL_RELU_EN.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  localparam int FM_W  = 30;
  localparam int W_W   = 18;
  localparam int ACC_W = 48;

  function automatic int out_size(
    input int fm,
    input int k,
    input int p,
    input int s
  );
    return ((fm - k + 2 * p) / s) + 1;
  endfunction

  function automatic int n_out(
    input int fm,
    input int k,
    input int p,
    input int s,
    input int mp
  );
    int o;
    o = out_size(fm, k, p, s);
    return (mp != 0) ? (o / 2) * (o / 2) : o * o;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_seq_cnt.sv
// conv_seq_cnt: wrap-around counter 0..MAX-1 with clear, increment
// and terminal-count flag.
module conv_seq_cnt
  import conv_pkg::*;
#(
  parameter int MAX = 4,
  localparam int CW = cw(MAX)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(MAX - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: loads weights, streams the FM and collects conv
// results into output BRAM. Optional ReLU: CONV_SEQ_CTRL_RELU_EN.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 250,
  parameter int PADDING     = 2,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0,
  parameter int FM_W        = conv_pkg::FM_W,
  parameter int W_W         = conv_pkg::W_W,
  parameter int ACC_W       = conv_pkg::ACC_W,
  parameter int DRAIN_TMO   = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_err,
  output logic [cw(KERNEL_SIZE*KERNEL_SIZE)-1:0] o_w_rd_addr,
  input  logic [W_W-1:0]   i_w_rd_data,
  output logic [cw(FM_SIZE*FM_SIZE)-1:0] o_fm_rd_addr,
  input  logic [FM_W-1:0]  i_fm_rd_data,
  output logic             o_conv_weight_en,
  output logic [W_W-1:0]   o_conv_weight_data,
  output logic             o_conv_go,
  output logic [FM_W-1:0]  o_conv_fm_data,
  input  logic             i_conv_en,
  input  logic [ACC_W-1:0] i_conv_result,
  output logic             o_out_wr_en,
  output logic [cw(n_out(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE, MAXPOOL))-1:0] o_out_wr_addr,
  output logic [ACC_W-1:0] o_out_wr_data
);

  localparam int WN    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FN    = FM_SIZE * FM_SIZE;
  localparam int N_OUT =
    n_out(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE, MAXPOOL);
  localparam int WA_W  = cw(WN);
  localparam int FA_W  = cw(FN);
  localparam int OA_W  = cw(N_OUT);
  localparam int TM_W  = cw(DRAIN_TMO + 1);

  seq_state_t state;
  seq_state_t state_nx;

  logic start_acc;
  logic w_issue;
  logic fm_inc;
  logic wr_acc;
  logic tmo_hit;

  logic gap_q;
  logic w_all_q;
  logic w_en_q;
  logic fm_last_q;
  logic wr_full_q;
  logic err_q;
  logic [TM_W-1:0] idle_q;

  logic             wr_en_q;
  logic [OA_W-1:0]  wr_addr_q;
  logic [ACC_W-1:0] wr_data_q;
  logic [ACC_W-1:0] res_cond;

  logic [WA_W-1:0] w_cnt;
  logic [FA_W-1:0] fm_cnt;
  logic [OA_W-1:0] wr_cnt;
  logic w_tc;
  logic fm_tc;
  logic wr_tc;

  assign start_acc = (state == ST_IDLE) && i_start;
  assign w_issue   = (state == ST_LOAD_W) && !w_all_q;
  assign fm_inc    = ((state == ST_GAP) && gap_q) ||
                     ((state == ST_STREAM) && !fm_last_q);
  assign wr_acc    = ((state == ST_STREAM) ||
                      (state == ST_DRAIN)) &&
                     i_conv_en && !wr_full_q;
  assign tmo_hit   = (state == ST_DRAIN) && !i_conv_en &&
                     !wr_full_q &&
                     (idle_q == TM_W'(DRAIN_TMO - 1));

  conv_seq_cnt #(.MAX(WN)) u_w_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr   (start_acc),
    .inc   (w_issue),
    .cnt   (w_cnt),
    .tc    (w_tc)
  );

  conv_seq_cnt #(.MAX(FN)) u_fm_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr   (start_acc),
    .inc   (fm_inc),
    .cnt   (fm_cnt),
    .tc    (fm_tc)
  );

  conv_seq_cnt #(.MAX(N_OUT)) u_wr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr   (start_acc),
    .inc   (wr_acc),
    .cnt   (wr_cnt),
    .tc    (wr_tc)
  );

`ifdef CONV_SEQ_CTRL_RELU_EN
  assign res_cond = i_conv_result[ACC_W-1] ? '0 : i_conv_result;
`else
  assign res_cond = i_conv_result;
`endif

  // LOAD_W holds one extra cycle so the last weight is presented
  // before GAP begins.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (i_start) state_nx = ST_LOAD_W;
      ST_LOAD_W: if (w_en_q && w_all_q) state_nx = ST_GAP;
      ST_GAP:    if (gap_q) state_nx = ST_STREAM;
      ST_STREAM: if (fm_last_q) state_nx = ST_DRAIN;
      ST_DRAIN:  if (wr_full_q || tmo_hit) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      gap_q     <= 1'b0;
      w_all_q   <= 1'b0;
      w_en_q    <= 1'b0;
      fm_last_q <= 1'b0;
      wr_full_q <= 1'b0;
      err_q     <= 1'b0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state  <= state_nx;
      w_en_q <= w_issue;
      gap_q  <= (state == ST_GAP) && !gap_q;
      if (start_acc) begin
        w_all_q   <= 1'b0;
        fm_last_q <= 1'b0;
        wr_full_q <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        if (w_issue && w_tc) w_all_q <= 1'b1;
        if (fm_inc && fm_tc) fm_last_q <= 1'b1;
        if (wr_acc && wr_tc) wr_full_q <= 1'b1;
        if (tmo_hit) err_q <= 1'b1;
      end
      if ((state != ST_DRAIN) || i_conv_en) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + TM_W'(1);
      end
      wr_en_q   <= wr_acc;
      wr_addr_q <= wr_acc ? wr_cnt : '0;
      wr_data_q <= wr_acc ? res_cond : '0;
    end
  end

  assign o_busy             = (state != ST_IDLE);
  assign o_done             = (state == ST_DONE);
  assign o_err              = err_q;
  assign o_w_rd_addr        = w_cnt;
  assign o_fm_rd_addr       = fm_cnt;
  assign o_conv_weight_en   = w_en_q;
  assign o_conv_weight_data = w_en_q ? i_w_rd_data : '0;
  assign o_conv_go          = (state == ST_STREAM) ||
                              (state == ST_DRAIN) ||
                              (state == ST_DONE);
  assign o_conv_fm_data     = (state == ST_STREAM) ?
                              i_fm_rd_data : '0;
  assign o_out_wr_en        = wr_en_q;
  assign o_out_wr_addr      = wr_addr_q;
  assign o_out_wr_data      = wr_data_q;

endmodule
